// File: rtl/keypad_field_writer_if.sv
// Field handshake between the keypad writer and its consumer, plus the live
// entry buffer for the display.
interface keypad_field_writer_if;
  logic [15:0] VALOR;
  logic [2:0]  CAMPO;
  logic        VALID;
  logic        READY;
  logic        DONE;
  logic [15:0] DIGITOS;

  modport master (output VALOR, CAMPO, VALID, DONE, DIGITOS, input READY);
  modport slave  (input VALOR, CAMPO, VALID, DONE, DIGITOS, output READY);
endinterface

// File: rtl/keypad_field_writer.sv
// Debounced keypad entry of up to four BCD digits per field; offers each
// completed field over a valid/ready handshake until NUM_FIELDS are sent.
module keypad_field_writer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NUM_FIELDS      = 7
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic [11:0] IO,
  keypad_field_writer_if.master bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {ENTRY, OFFER, FINISHED} state_t;

  logic [11:0]   sync1, sync2, cand, stable, stable_d;
  logic [CW-1:0] cnt;
  logic [11:0]   rise;
  logic          ev_clear, ev_next, ev_digit;
  logic [3:0]    dval;

  state_t        state;
  logic [15:0]   valor, digitos;
  logic [2:0]    campo, ndig;
  logic          valid, done;

  // cnt is the number of identical samples seen so far, including the current cand
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sync1    <= '0;
      sync2    <= '0;
      cand     <= '0;
      cnt      <= '0;
      stable   <= '0;
      stable_d <= '0;
    end else begin
      sync1    <= IO;
      sync2    <= sync1;
      stable_d <= stable;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= CW'(1);
        if (DEBOUNCE_CYCLES <= 1) stable <= sync2;
      end else if (cnt >= CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= cand;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    rise     = stable & ~stable_d;
    ev_clear = rise[11];
    ev_next  = !rise[11] && rise[10];
    // an ambiguous chord of digits is dropped rather than guessed
    ev_digit = !rise[11] && !rise[10] && (|rise[9:0]) &&
               ($countones(stable[9:0]) == 1);
    dval = 4'd0;
    for (int i = 0; i < 10; i++)
      if (rise[i]) dval = 4'(i);
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state   <= ENTRY;
      valor   <= '0;
      digitos <= '0;
      campo   <= '0;
      ndig    <= '0;
      valid   <= 1'b0;
      done    <= 1'b0;
    end else if (ev_clear) begin
      state   <= ENTRY;
      valor   <= '0;
      digitos <= '0;
      campo   <= '0;
      ndig    <= '0;
      valid   <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ENTRY: begin
          if (ev_next) begin
            valor <= digitos;
            valid <= 1'b1;
            state <= OFFER;
          end else if (ev_digit && ndig < 3'd4) begin
            digitos <= {digitos[11:0], dval};
            ndig    <= ndig + 1'b1;
          end
        end
        OFFER: begin
          if (valid && bus.READY) begin
            valid   <= 1'b0;
            digitos <= '0;
            ndig    <= '0;
            if (campo == 3'(NUM_FIELDS - 1)) begin
              done  <= 1'b1;
              state <= FINISHED;
            end else begin
              campo <= campo + 1'b1;
              state <= ENTRY;
            end
          end
        end
        FINISHED: begin
          if (ev_next) begin
            campo <= '0;
            done  <= 1'b0;
            state <= ENTRY;
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

  assign bus.VALOR   = valor;
  assign bus.CAMPO   = campo;
  assign bus.VALID   = valid;
  assign bus.DONE    = done;
  assign bus.DIGITOS = digitos;
endmodule

// File: tb/tb_keypad_field_writer.sv
// Randomized key presses checked against a press-level model of field entry.
module tb_keypad_field_writer;
  localparam int DEB = 4;
  localparam int NF  = 7;
  localparam int HOLD = DEB + 4;
  localparam int REL  = DEB + 8;

  logic        CLOCK_50 = 1'b0;
  logic        RESET    = 1'b1;
  logic [11:0] IO       = '0;

  keypad_field_writer_if bus();

  keypad_field_writer #(.DEBOUNCE_CYCLES(DEB), .NUM_FIELDS(NF)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .IO       (IO),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model: digits typed for the current field, and the outcome of each transfer
  int          m_dig[$];
  bit          m_valid, m_done;
  int          m_field, m_valor;
  logic [18:0] exp_q[$];
  logic [18:0] obs_q[$];

  always @(negedge CLOCK_50)
    if (!RESET && bus.VALID && bus.READY) obs_q.push_back({bus.CAMPO, bus.VALOR});

  function automatic int digits_value();
    int v = 0;
    foreach (m_dig[i]) v = v * 16 + m_dig[i];
    return v;
  endfunction

  function automatic void model_reset();
    m_dig.delete();
    m_valid = 0; m_done = 0; m_field = 0; m_valor = 0;
  endfunction

  function automatic void model_xfer();
    exp_q.push_back({3'(m_field), 16'(m_valor)});
    m_valid = 0;
    m_dig.delete();
    if (m_field == NF - 1) m_done = 1;
    else m_field++;
  endfunction

  function automatic void model_key(input logic [11:0] mask, input bit rdy);
    if (mask[11]) model_reset();
    else if (mask[10]) begin
      if (m_done) begin m_done = 0; m_field = 0; end
      else if (!m_valid) begin
        m_valor = digits_value();
        m_valid = 1;
        if (rdy) model_xfer();
      end
    end else if ($countones(mask[9:0]) == 1 && !m_valid && !m_done && m_dig.size() < 4) begin
      for (int i = 0; i < 10; i++) if (mask[i]) m_dig.push_back(i);
    end
  endfunction

  task automatic press(input logic [11:0] mask, input int hold);
    @(posedge CLOCK_50); #1 IO = mask;
    repeat (hold) @(posedge CLOCK_50);
    #1 IO = '0;
    if (hold >= DEB) model_key(mask, bus.READY);
    repeat (REL) @(posedge CLOCK_50);
  endtask

  task automatic set_ready(input logic r);
    @(posedge CLOCK_50); #1 bus.READY = r;
    if (r && m_valid) model_xfer();
    repeat (2) @(posedge CLOCK_50);
  endtask

  task automatic check_all(input string tag);
    logic [18:0] o, e;
    @(negedge CLOCK_50);
    check({tag, ".digitos"}, bus.DIGITOS, (m_valid || m_done) ? (m_valid ? digits_value() : 0) : digits_value());
    check({tag, ".valor"}, bus.VALOR, m_valor);
    check({tag, ".campo"}, bus.CAMPO, m_field);
    check({tag, ".valid"}, bus.VALID, m_valid);
    check({tag, ".done"}, bus.DONE, m_done);
    check({tag, ".xfers"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, ".xfer"}, o, e);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic type_digits(input int a, input int b, input int c);
    press(12'(1) << a, HOLD);
    press(12'(1) << b, HOLD);
    press(12'(1) << c, HOLD);
  endtask

  initial begin
    logic [11:0] mask;
    int pick, a, b;
    bus.READY = 1'b0;
    model_reset();
    repeat (3) @(posedge CLOCK_50);
    #2;
    check("rst.valor", bus.VALOR, 0);
    check("rst.digitos", bus.DIGITOS, 0);
    check("rst.campo", bus.CAMPO, 0);
    check("rst.valid", bus.VALID, 0);
    check("rst.done", bus.DONE, 0);
    @(posedge CLOCK_50); #1 RESET = 1'b0;
    repeat (2) @(posedge CLOCK_50);

    // digits 1,2,0 then NEXT with READY low: offer is held
    type_digits(1, 2, 0);
    press(12'h400, HOLD);
    repeat (10) @(posedge CLOCK_50);
    check_all("r33");
    check("r33.valor", bus.VALOR, 16'h0120);
    check("r33.valid", bus.VALID, 1);
    set_ready(1'b1);
    set_ready(1'b0);
    check_all("r33x");

    // five digits with READY high: fifth ignored, offer taken at once
    press(12'h800, HOLD);
    set_ready(1'b1);
    type_digits(9, 8, 7);
    press(12'(1) << 6, HOLD);
    press(12'(1) << 5, HOLD);
    check("r34.dig", bus.DIGITOS, 16'h9876);
    press(12'h400, HOLD);
    check("r34.xval", obs_q.size() > 0 ? obs_q[0][15:0] : 16'hdead, 16'h9876);
    check_all("r34");
    check("r34.campo", bus.CAMPO, 1);
    check("r34.digitos", bus.DIGITOS, 0);

    // short glitch on 3 is filtered, clean 4 is taken
    for (int h = 1; h < DEB; h++) press(12'(1) << 3, h);
    press(12'(1) << 4, HOLD);
    check("r35.dig", bus.DIGITOS, 16'h0004);
    check_all("r35");

    // finish the session with READY high, then NEXT restarts it
    for (int f = 1; f < NF; f++) begin
      press(12'(1) << $urandom_range(0, 9), HOLD);
      press(12'h400, HOLD);
    end
    check_all("r36");
    check("r36.done", bus.DONE, 1);
    check("r36.campo", bus.CAMPO, NF - 1);
    press(12'h400, HOLD);
    check("r36.done0", bus.DONE, 0);
    check("r36.campo0", bus.CAMPO, 0);
    check_all("r36b");

    // CLEAR while an offer is pending
    set_ready(1'b0);
    press(12'(1) << 2, HOLD);
    press(12'h400, HOLD);
    press(12'h400, HOLD);
    press(12'h800, HOLD);
    check("r37.valid", bus.VALID, 0);
    check("r37.campo", bus.CAMPO, 0);
    check_all("r37");

    // chords: two digits ignored, NEXT with a digit is NEXT only
    press(12'(1) << 7, HOLD);
    press((12'(1) << 2) | (12'(1) << 5), HOLD);
    check("r39.chord", bus.DIGITOS, 16'h0007);
    press(12'h400 | (12'(1) << 5), HOLD);
    check("r39.next", bus.VALOR, 16'h0007);
    check_all("r39");
    set_ready(1'b1);
    check_all("r39x");

    for (int n = 0; n < 70; n++) begin
      pick = $urandom_range(0, 99);
      if (pick < 8) set_ready(1'($urandom_range(0, 1)));
      a = $urandom_range(0, 9);
      b = (a + $urandom_range(1, 9)) % 10;
      if (pick < 60)      mask = 12'(1) << a;
      else if (pick < 80) mask = 12'h400 | ($urandom_range(0, 1) ? 12'(1) << a : 12'h000);
      else if (pick < 86) mask = (12'(1) << a) | (12'(1) << b);
      else if (pick < 89) mask = 12'h800 | 12'($urandom_range(0, 12'h7ff));
      else                mask = 12'(1) << a;
      press(mask, (pick >= 89) ? $urandom_range(1, DEB - 1) : HOLD);
      check_all($sformatf("rnd%0d", n));
    end

    // asynchronous reset during an offer
    set_ready(1'b0);
    press(12'h800, HOLD);
    press(12'(1) << 3, HOLD);
    press(12'h400, HOLD);
    check_all("r38pre");
    @(posedge CLOCK_50); #3 RESET = 1'b1;
    #1;
    check("r38.valor", bus.VALOR, 0);
    check("r38.valid", bus.VALID, 0);
    check("r38.digitos", bus.DIGITOS, 0);
    check("r38.campo", bus.CAMPO, 0);
    check("r38.done", bus.DONE, 0);
    model_reset();
    @(posedge CLOCK_50); #1 RESET = 1'b0;
    press(12'(1) << 8, HOLD);
    check_all("r38post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/keypad_field_writer.md
KEYPAD_FIELD_WRITER -- requirements
Module: keypad_field_writer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive cycles a sampled key vector must stay unchanged before it is accepted.
REQ-002 Parameter NUM_FIELDS, default 7: number of fields per entry session, indexed 0..NUM_FIELDS-1.
REQ-003 CLOCK_50  in  1: single clock; all logic on its rising edge.
REQ-004 RESET  in  1: asynchronous, active-high reset.
REQ-005 IO  in  12: raw keys; bits 0..9 are digits 0..9, bit 10 NEXT, bit 11 CLEAR; active-high and asynchronous to CLOCK_50.
REQ-006 VALOR  out  16: four BCD digits of the offered value, [15:12] most significant.
REQ-007 CAMPO  out  3: index of the field currently being entered.
REQ-008 VALID  out  1: VALOR/CAMPO hold a completed field for the consumer.
REQ-009 READY  in  1: consumer accepts the field when READY and VALID are both high at a clock edge.
REQ-010 DONE  out  1: all NUM_FIELDS fields have been transferred.
REQ-011 DIGITOS  out  16: live BCD entry buffer for the display, same layout as VALOR.

Function
REQ-012 IO shall pass through a 2-flop synchronizer before any other use.
REQ-013 Debounce: the synchronized vector is accepted after DEBOUNCE_CYCLES consecutive identical samples; any change restarts the count.
REQ-014 Key event: a bit going 0->1 in the accepted vector produces a one-cycle event; holding a key produces no repeat events.
REQ-015 Priority: CLEAR over NEXT over digits; a newly accepted vector with two or more digit bits set produces no digit event.
REQ-016 Latency: a clean key press updates registers within 2+DEBOUNCE_CYCLES+1 cycles of the IO edge.
REQ-017 The state machine shall have three states: ENTRY, OFFER and FINISHED.
REQ-018 ENTRY, digit event: DIGITOS shifts left one BCD digit, and the new digit enters [3:0].
REQ-019 ENTRY, digit event: the digit count increments.
REQ-020 ENTRY, digit event with 4 digits already entered: the event is ignored and DIGITOS is unchanged.
REQ-021 ENTRY, NEXT event: VALOR <= DIGITOS, VALID <= 1, and the state goes to OFFER; zero digits entered gives a value of 0.
REQ-022 OFFER: VALID, VALOR and CAMPO shall stay stable until the transfer; digit and NEXT events are ignored.
REQ-023 OFFER, READY&VALID at an edge: the next cycle has VALID=0, DIGITOS=0 and digit count=0.
REQ-024 OFFER, READY&VALID at an edge: if CAMPO < NUM_FIELDS-1, CAMPO increments and the state goes to ENTRY.
REQ-025 OFFER, READY&VALID at an edge with CAMPO = NUM_FIELDS-1: CAMPO holds, DONE <= 1 and the state goes to FINISHED.
REQ-026 FINISHED: digit events are ignored.
REQ-027 FINISHED, NEXT event: CAMPO <= 0, DONE <= 0 and the state goes to ENTRY, starting a new session.
REQ-028 CLEAR event in any state: on the next edge all registers take their reset values, including VALID=0, even mid-offer.
REQ-029 READY while VALID=0 shall have no effect.

Reset
REQ-030 While RESET is high, immediately and independent of CLOCK_50: VALOR=0, DIGITOS=0, CAMPO=0, VALID=0, DONE=0, and the state is ENTRY.
REQ-031 While RESET is high, the synchronizer, debounce counter, accepted vector and digit count are cleared to 0.
REQ-032 The first key event after RESET deasserts requires full debounce (REQ-013).

Verification (DEBOUNCE_CYCLES=4, NUM_FIELDS=7)
REQ-033 Press digits 1,2,0 cleanly, then NEXT with READY=0 -> VALOR=0x0120, VALID=1 held, CAMPO=0.
REQ-034 Press digits 9,8,7,6,5, then NEXT, with READY=1 -> VALOR=0x9876 for one cycle; then VALID=0, CAMPO=1, DIGITOS=0.
REQ-035 Bounce digit 3 with a pulse shorter than 4 cycles, then hold digit 4 -> DIGITOS=0x0004 only.
REQ-036 Send 7 fields with READY=1 -> DONE=1 after the 7th transfer and CAMPO=6; then NEXT -> DONE=0, CAMPO=0.
REQ-037 Press CLEAR while VALID=1 -> VALID=0 and CAMPO=0 on the next edge after the event.
REQ-038 Assert RESET asynchronously in OFFER -> all outputs are 0 before the next CLOCK_50 edge.
REQ-039 Hold digits 2 and 5 simultaneously -> no change; hold NEXT and 5 simultaneously -> a NEXT event only.
